// File: rtl/dram_bank_model.sv
// dram_bank_model
//   Cycle-accurate single-bank DRAM device model. Decodes the pin-level
//   command bus, tracks the row buffer through CLOSED/OPENING/OPEN/CLOSING,
//   enforces tRCD / CAS latency / tRP, returns read data after T_CL cycles,
//   and pulses err for one cycle on any illegal command.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset (array contents are kept)
//   DRAM_CSn    chip select, active low
//   DRAM_RASn   row strobe, active low
//   DRAM_CASn   column strobe, active low
//   DRAM_WEn    per-byte write enable, active low (bit i = byte i)
//   DRAM_A      multiplexed row/column address
//   DRAM_D      write data
//   DRAM_Q      read data, holds last returned word
//   DRAM_valid  one-cycle strobe per returned word
//   err         one-cycle pulse, cycle after an illegal command edge
module dram_bank_model #(
   parameter int ROW_W = 11,
   parameter int COL_W = 10,
   parameter int T_RCD = 5,
   parameter int T_CL  = 5,
   parameter int T_RP  = 5
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            DRAM_CSn,
   input  logic                                            DRAM_RASn,
   input  logic                                            DRAM_CASn,
   input  logic [3:0]                                      DRAM_WEn,
   input  logic [((ROW_W > COL_W) ? ROW_W : COL_W)-1:0]    DRAM_A,
   input  logic [31:0]                                     DRAM_D,
   output logic [31:0]                                     DRAM_Q,
   output logic                                            DRAM_valid,
   output logic                                            err
);

   localparam int MEM_DEPTH = 2 ** (ROW_W + COL_W);
   localparam int MAX_T     = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int CNT_W     = (MAX_T > 2) ? $clog2(MAX_T) : 1;

   localparam logic [1:0] ST_CLOSED  = 2'd0;
   localparam logic [1:0] ST_OPENING = 2'd1;
   localparam logic [1:0] ST_OPEN    = 2'd2;
   localparam logic [1:0] ST_CLOSING = 2'd3;

   // storage: never reset
   logic [31:0] mem_q [0:MEM_DEPTH-1];

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [T_CL-1:0]       vld_pipe_q, vld_pipe_d;
   logic [T_CL-1:0][31:0] dat_pipe_q, dat_pipe_d;
   logic                  valid_q, valid_d;
   logic [31:0]           q_q, q_d;
   logic                  err_q, err_d;

   logic                     sel, is_nop, is_bad_pins, mask_all;
   logic                     is_act, is_pre, is_rd, is_wr;
   logic                     illegal, rd_ok, wr_ok;
   logic [ROW_W+COL_W-1:0]   addr;

   // ---------------------------------------------------------------- decode
   always_comb begin
      sel         = !DRAM_CSn;
      mask_all    = (DRAM_WEn == 4'hF);
      is_nop      = DRAM_CSn || (DRAM_RASn && DRAM_CASn);
      is_bad_pins = sel && !DRAM_RASn && !DRAM_CASn;
      is_act      = sel && !DRAM_RASn &&  DRAM_CASn &&  mask_all;
      is_pre      = sel && !DRAM_RASn &&  DRAM_CASn && !mask_all;
      is_rd       = sel &&  DRAM_RASn && !DRAM_CASn &&  mask_all;
      is_wr       = sel &&  DRAM_RASn && !DRAM_CASn && !mask_all;
      addr        = {row_q, DRAM_A[COL_W-1:0]};
   end

   // ------------------------------------------------------------- bank FSM
   // The counter holds the number of edges still to wait; the state flips
   // on the edge where it would reach zero, so the first legal command lands
   // exactly T_RCD (or T_RP) edges after ACT (or PRE). A delay of 1 skips
   // the transitional state entirely. Illegal commands are ignored but do
   // not stall the timers, which model elapsed device time.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      illegal = is_bad_pins;
      rd_ok   = 1'b0;
      wr_ok   = 1'b0;
      case (state_q)
         ST_CLOSED: begin
            if (is_act) begin
               row_d = DRAM_A[ROW_W-1:0];
               if (T_RCD == 1) begin
                  state_d = ST_OPEN;
               end else begin
                  state_d = ST_OPENING;
                  cnt_d   = CNT_W'(T_RCD - 1);
               end
            end else if (is_rd || is_wr) begin
               illegal = 1'b1;
            end
         end
         ST_OPENING: begin
            if (!is_nop) illegal = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_OPEN;
         end
         ST_OPEN: begin
            if (is_rd) begin
               rd_ok = 1'b1;
            end else if (is_wr) begin
               wr_ok = 1'b1;
            end else if (is_pre) begin
               if (T_RP == 1) begin
                  state_d = ST_CLOSED;
               end else begin
                  state_d = ST_CLOSING;
                  cnt_d   = CNT_W'(T_RP - 1);
               end
            end else if (is_act) begin
               illegal = 1'b1;
            end
         end
         default: begin // ST_CLOSING
            if (!is_nop) illegal = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_CLOSED;
         end
      endcase
      err_d = illegal;
   end

   // --------------------------------------------------------- read pipeline
   // Stage 0 captures the array word at the RD edge; after T_CL-1 shifts
   // the word sits in the last stage and the output register presents it
   // in the cycle following edge N+T_CL.
   always_comb begin
      vld_pipe_d    = '0;
      dat_pipe_d    = '0;
      vld_pipe_d[0] = rd_ok;
      dat_pipe_d[0] = rd_ok ? mem_q[addr] : 32'h0;
      for (int i = 1; i < T_CL; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
         dat_pipe_d[i] = dat_pipe_q[i-1];
      end
      valid_d = vld_pipe_q[T_CL-1];
      q_d     = valid_d ? dat_pipe_q[T_CL-1] : q_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_CLOSED;
         cnt_q      <= '0;
         row_q      <= '0;
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
         valid_q    <= 1'b0;
         q_q        <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         row_q      <= row_d;
         vld_pipe_q <= vld_pipe_d;
         dat_pipe_q <= dat_pipe_d;
         valid_q    <= valid_d;
         q_q        <= q_d;
         err_q      <= err_d;
      end
   end

   // Byte-masked write at the command edge. wr_ok is only asserted in OPEN,
   // which reset forces away from, so no explicit reset gating is needed.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (!DRAM_WEn[i]) mem_q[addr][8*i +: 8] <= DRAM_D[8*i +: 8];
         end
      end
   end

   assign DRAM_Q     = q_q;
   assign DRAM_valid = valid_q;
   assign err        = err_q;

endmodule

// File: tb/tb_dram_bank_model.sv
// Directed bench for dram_bank_model with default parameters.
// Inputs change 1ns after a rising edge; outputs are checked right after,
// so each check observes the registered result of the preceding edge.
module tb_dram_bank_model;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csn = 1'b1, rasn = 1'b1, casn = 1'b1;
   logic [3:0]  wen = 4'hF;
   logic [10:0] a   = '0;
   logic [31:0] d   = '0;
   logic [31:0] q;
   logic        valid, err;

   int errors = 0;
   int checks = 0;

   logic [31:0] bdat [4];

   dram_bank_model dut (
      .clk        (clk),
      .rst        (rst),
      .DRAM_CSn   (csn),
      .DRAM_RASn  (rasn),
      .DRAM_CASn  (casn),
      .DRAM_WEn   (wen),
      .DRAM_A     (a),
      .DRAM_D     (d),
      .DRAM_Q     (q),
      .DRAM_valid (valid),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // drive one command for exactly one rising edge, then return to NOP
   task automatic drive(input logic cs, input logic ras, input logic cas,
                        input logic [3:0] we, input logic [10:0] ad, input logic [31:0] dd);
      csn = cs; rasn = ras; casn = cas; wen = we; a = ad; d = dd;
      @(posedge clk);
      #1;
      csn = 1'b1; rasn = 1'b1; casn = 1'b1; wen = 4'hF; a = '0; d = '0;
   endtask

   task automatic nop(input int n);
      repeat (n) drive(1'b1, 1'b1, 1'b1, 4'hF, 11'd0, 32'h0);
   endtask
   task automatic act(input logic [10:0] r);
      drive(1'b0, 1'b0, 1'b1, 4'hF, r, 32'h0);
   endtask
   task automatic pre();
      drive(1'b0, 1'b0, 1'b1, 4'h0, 11'd0, 32'h0);
   endtask
   task automatic rd(input logic [10:0] c);
      drive(1'b0, 1'b1, 1'b0, 4'hF, c, 32'h0);
   endtask
   task automatic wr(input logic [10:0] c, input logic [3:0] m, input logic [31:0] dd);
      drive(1'b0, 1'b1, 1'b0, m, c, dd);
   endtask

   initial begin
      bdat[0] = 32'h0A0A0001; bdat[1] = 32'h0B0B0002;
      bdat[2] = 32'h0C0C0003; bdat[3] = 32'h0D0D0004;

      // reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_q", q, 32'h0);
      chk("rst_err", {31'b0, err}, 32'd0);
      rst = 1'b0;

      // preload through the command bus: row 3 and row 9
      act(11'd3); nop(4);
      wr(11'd7, 4'h0, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) wr(11'(i), 4'h0, bdat[i]);
      wr(11'd9, 4'h0, 32'h11223344);
      pre(); nop(4);
      act(11'd9); nop(4);
      wr(11'd4, 4'h0, 32'hCAFEF00D);
      pre(); nop(4);
      chk("preload_err", {31'b0, err}, 32'd0);

      // basic read, PRE with read in flight, row change, second read
      for (int e = 0; e <= 22; e++) begin
         case (e)
            0:       act(11'd3);
            5:       rd(11'd7);
            6:       pre();
            11:      act(11'd9);
            16:      rd(11'd4);
            default: nop(1);
         endcase
         chk($sformatf("A_err_e%0d", e), {31'b0, err}, 32'd0);
         chk($sformatf("A_valid_e%0d", e), {31'b0, valid}, {31'b0, (e == 10 || e == 21)});
         if (e == 10) chk("A_q_row3", q, 32'hDEADBEEF);
         if (e == 21) chk("A_q_row9", q, 32'hCAFEF00D);
      end

      // ACT while OPEN: err, row stays 9
      act(11'd3);
      chk("B_act_open_err", {31'b0, err}, 32'd1);
      nop(1);
      chk("B_err_oneshot", {31'b0, err}, 32'd0);
      rd(11'd4); nop(4);
      chk("B_valid_early", {31'b0, valid}, 32'd0);
      nop(1);
      chk("B_valid", {31'b0, valid}, 32'd1);
      chk("B_row_kept", q, 32'hCAFEF00D);

      // ACT two edges after PRE, then early RD, then pipelined reads
      pre(); nop(1);
      act(11'd3);
      chk("C_act_trp_err", {31'b0, err}, 32'd1);
      nop(2);
      act(11'd3);
      chk("C_act_ok", {31'b0, err}, 32'd0);
      nop(2);
      rd(11'd7);
      chk("C_rd_trcd_err", {31'b0, err}, 32'd1);
      nop(1);
      for (int i = 0; i < 10; i++) begin
         if (i < 4) rd(11'(i)); else nop(1);
         chk($sformatf("C_valid_i%0d", i), {31'b0, valid}, {31'b0, (i >= 5 && i <= 8)});
         if (i >= 5 && i <= 8) chk($sformatf("C_q_i%0d", i), q, bdat[i-5]);
         chk($sformatf("C_err_i%0d", i), {31'b0, err}, 32'd0);
      end
      chk("C_q_hold", q, bdat[3]);

      // byte-masked write, read back on the very next edge
      wr(11'd9, 4'b1010, 32'hAABBCCDD);
      rd(11'd9); nop(5);
      chk("D_valid", {31'b0, valid}, 32'd1);
      chk("D_masked", q, 32'h11BB33DD);

      // RAS and CAS both low is always illegal
      drive(1'b0, 1'b0, 1'b0, 4'hF, 11'd0, 32'h0);
      chk("D_ras_cas_err", {31'b0, err}, 32'd1);

      // asynchronous reset two cycles after a read
      rd(11'd7); nop(2);
      #2 rst = 1'b1;
      #1;
      chk("E_rst_q", q, 32'h0);
      chk("E_rst_valid", {31'b0, valid}, 32'd0);
      nop(2);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nop(1);
         chk($sformatf("E_no_valid_%0d", i), {31'b0, valid}, 32'd0);
      end
      chk("E_q_zero", q, 32'h0);
      rd(11'd7);
      chk("E_closed_rd_err", {31'b0, err}, 32'd1);

      // array contents survive reset
      act(11'd3); nop(4); rd(11'd7); nop(5);
      chk("E_retain_valid", {31'b0, valid}, 32'd1);
      chk("E_retain_q", q, 32'hDEADBEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
